// File: rtl/seq_timing_decoder.sv
// Sequence counter with registered one-hot timing decode, terminal-count wrap and load range check.
// Optional one-hot checker on the timing outputs is built when SEQ_TIMING_ONEHOT_CHK_EN is defined.
module seq_timing_decoder #(
    parameter int SEL_W    = 4,
    parameter int MAX_STEP = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [SEL_W-1:0]      ld_val,
    input  logic                  inc,
    output logic [SEL_W-1:0]      sc,
    output logic [2**SEL_W-1:0]   t,
    output logic                  wrap,
    output logic                  ld_err,
    output logic                  onehot_err
);

    localparam int N_OUT = 2**SEL_W;
    localparam logic [SEL_W-1:0] MAX_SC = SEL_W'(MAX_STEP);

    if (MAX_STEP < 1 || MAX_STEP > N_OUT - 1) begin : g_bad_max_step
        $error("seq_timing_decoder: MAX_STEP out of range 1..N_OUT-1");
    end

    function automatic logic [N_OUT-1:0] decode(input logic [SEL_W-1:0] v);
        decode = {{(N_OUT-1){1'b0}}, 1'b1} << v;
    endfunction

    logic [SEL_W-1:0] sc_nxt;
    logic             wrap_nxt;
    logic             ld_err_nxt;

    // Priority clr > ld > inc > hold; an out-of-range load still blocks inc.
    always_comb begin
        sc_nxt     = sc;
        wrap_nxt   = 1'b0;
        ld_err_nxt = 1'b0;
        if (clr) begin
            sc_nxt = '0;
        end else if (ld) begin
            if (ld_val <= MAX_SC) begin
                sc_nxt = ld_val;
            end else begin
                ld_err_nxt = 1'b1;
            end
        end else if (inc) begin
            if (sc == MAX_SC) begin
                sc_nxt   = '0;
                wrap_nxt = 1'b1;
            end else begin
                sc_nxt = sc + 1'b1;
            end
        end
    end

    // t is re-decoded from the next count every edge so it can never drift from sc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc     <= '0;
            t      <= decode('0);
            wrap   <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            sc     <= sc_nxt;
            t      <= decode(sc_nxt);
            wrap   <= wrap_nxt;
            ld_err <= ld_err_nxt;
        end
    end

`ifdef SEQ_TIMING_ONEHOT_CHK_EN
    logic viol;

    always_comb begin
        viol = (t == '0) || ((t & (t - 1'b1)) != '0) || !t[sc];
    end

    // Sticky until an explicit clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err <= 1'b0;
        end else if (clr) begin
            onehot_err <= 1'b0;
        end else if (viol) begin
            onehot_err <= 1'b1;
        end
    end
`else
    assign onehot_err = 1'b0;
`endif

endmodule
